// File: rtl/z80_sys_ctrl.sv
// System controller for the Z80 mini computer: delayed CPU reset, memory/I/O decode, wait states, read mux.
// Optional sticky unmapped-I/O error capture is enabled by defining Z80_SYS_BUS_ERR_EN.
module z80_sys_ctrl #(
    parameter int unsigned RST_CYCLES   = 8,
    parameter logic [15:0] ROM_END      = 16'h7FFF,
    parameter logic [7:0]  IO_BASE      = 8'h84,
    parameter int unsigned NUM_IO       = 4,
    parameter int unsigned IO_SPAN_LOG2 = 1,
    parameter int unsigned MEM_WAIT     = 0,
    parameter int unsigned IO_WAIT      = 2
) (
    input  logic                cpu_clk,
    input  logic                n_RST,
    input  logic [15:0]         i_cpu_addr,
    input  logic                i_cpu_mreq,
    input  logic                i_cpu_iorq,
    input  logic                i_cpu_rd,
    input  logic                i_cpu_wr,
    output logic                o_cpu_rst,
    output logic                o_cpu_wait,
    output logic                o_rom_ce,
    output logic                o_ram_ce,
    output logic [NUM_IO-1:0]   o_io_ce,
    input  logic [7:0]          i_rom_data,
    input  logic [7:0]          i_ram_data,
    input  logic [8*NUM_IO-1:0] i_io_data,
    output logic [7:0]          o_cpu_data_in,
    output logic                o_bus_err,
    output logic [7:0]          o_err_port
);

    localparam logic [7:0] RST_TARGET  = 8'(RST_CYCLES);
    localparam logic [3:0] MEM_N       = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N        = 4'(IO_WAIT);
    localparam logic [7:0] IO_BASE_IDX = IO_BASE >> IO_SPAN_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    logic [7:0]        r_rst_cnt;
    logic              w_cpu_rst;
    logic [7:0]        w_io_idx;
    logic              w_rom_ce;
    logic              w_ram_ce;
    logic [NUM_IO-1:0] w_io_ce;
    logic [7:0]        w_rd_data;
    logic              w_access;
    logic [3:0]        w_n;
    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic              w_wait;

    // ---------------- Reset sequencer ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            r_rst_cnt <= '0;
        end else if (r_rst_cnt < RST_TARGET) begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
        end
    end

    assign w_cpu_rst = (r_rst_cnt < RST_TARGET);

    // ---------------- Address decode ----------------
    assign w_io_idx = i_cpu_addr[7:0] >> IO_SPAN_LOG2;

    always_comb begin
        w_rom_ce = i_cpu_mreq & ~w_cpu_rst & (i_cpu_addr <= ROM_END);
        w_ram_ce = i_cpu_mreq & ~w_cpu_rst & (i_cpu_addr > ROM_END);
        for (int k = 0; k < NUM_IO; k++) begin
            w_io_ce[k] = i_cpu_iorq & ~w_cpu_rst & (w_io_idx == IO_BASE_IDX + 8'(k));
        end
    end

    // ---------------- Read data mux ----------------
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_rd_data = 8'hFF;
        if (i_cpu_rd) begin
            if (w_rom_ce) begin
                w_rd_data = i_rom_data;
            end else if (w_ram_ce) begin
                w_rd_data = i_ram_data;
            end else begin
                for (int k = 0; k < NUM_IO; k++) begin
                    if (w_io_ce[k]) begin
                        w_rd_data = i_io_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------- Wait-state FSM ----------------
    assign w_access = (i_cpu_mreq | i_cpu_iorq) & (i_cpu_rd | i_cpu_wr) & ~w_cpu_rst;
    assign w_n      = i_cpu_iorq ? IO_N : MEM_N;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_wait       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_n == 4'd0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        // The first wait cycle is the access cycle itself, so only N-1 remain.
                        w_wait       = 1'b1;
                        w_next_cnt   = w_n - 4'd1;
                        w_next_state = (w_n > 4'd1) ? ST_WAIT : ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_access) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_wait     = 1'b1;
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!w_access) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_cpu_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // ---------------- Unmapped I/O capture ----------------
`ifdef Z80_SYS_BUS_ERR_EN
    logic       r_bus_err;
    logic [7:0] r_err_port;
    logic       w_err_hit;

    assign w_err_hit = (r_state == ST_IDLE) & w_access & i_cpu_iorq & ~(|w_io_ce) & ~r_bus_err;

    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            r_bus_err  <= 1'b0;
            r_err_port <= 8'h00;
        end else if (w_err_hit) begin
            r_bus_err  <= 1'b1;
            r_err_port <= i_cpu_addr[7:0];
        end
    end

    assign o_bus_err  = r_bus_err;
    assign o_err_port = r_err_port;
`else
    assign o_bus_err  = 1'b0;
    assign o_err_port = 8'h00;
`endif

    assign o_cpu_rst     = w_cpu_rst;
    assign o_cpu_wait    = w_wait;
    assign o_rom_ce      = w_rom_ce;
    assign o_ram_ce      = w_ram_ce;
    assign o_io_ce       = w_io_ce;
    assign o_cpu_data_in = w_rd_data;

endmodule

// File: tb/tb_z80_sys_ctrl.sv
// Self-checking bench for z80_sys_ctrl: reset sequencing, decode, read mux, wait states, unmapped-I/O capture.
// Expected results are queued as each access is driven and compared when that access completes.
module tb_z80_sys_ctrl;

    localparam int RST_CYCLES = 8;
    localparam int NUM_IO     = 4;
    localparam int MEM_WAIT   = 0;
    localparam int IO_WAIT    = 2;
`ifdef Z80_SYS_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                cpu_clk = 1'b0;
    logic                n_RST   = 1'b0;
    logic [15:0]         cpu_addr = '0;
    logic                cpu_mreq = 1'b0;
    logic                cpu_iorq = 1'b0;
    logic                cpu_rd   = 1'b0;
    logic                cpu_wr   = 1'b0;
    logic                cpu_rst;
    logic                cpu_wait;
    logic                rom_ce;
    logic                ram_ce;
    logic [NUM_IO-1:0]   io_ce;
    logic [7:0]          rom_data = 8'h3E;
    logic [7:0]          ram_data = 8'hA5;
    logic [8*NUM_IO-1:0] io_data  = {8'h44, 8'h33, 8'h22, 8'h5A};
    logic [7:0]          cpu_data_in;
    logic                bus_err;
    logic [7:0]          err_port;

    logic [7:0] io_bytes [NUM_IO] = '{8'h5A, 8'h22, 8'h33, 8'h44};

    always #5 cpu_clk = ~cpu_clk;

    z80_sys_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .ROM_END     (16'h7FFF),
        .IO_BASE     (8'h84),
        .NUM_IO      (NUM_IO),
        .IO_SPAN_LOG2(1),
        .MEM_WAIT    (MEM_WAIT),
        .IO_WAIT     (IO_WAIT)
    ) dut (
        .cpu_clk      (cpu_clk),
        .n_RST        (n_RST),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_mreq   (cpu_mreq),
        .i_cpu_iorq   (cpu_iorq),
        .i_cpu_rd     (cpu_rd),
        .i_cpu_wr     (cpu_wr),
        .o_cpu_rst    (cpu_rst),
        .o_cpu_wait   (cpu_wait),
        .o_rom_ce     (rom_ce),
        .o_ram_ce     (ram_ce),
        .o_io_ce      (io_ce),
        .i_rom_data   (rom_data),
        .i_ram_data   (ram_data),
        .i_io_data    (io_data),
        .o_cpu_data_in(cpu_data_in),
        .o_bus_err    (bus_err),
        .o_err_port   (err_port)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string             tag;
        logic              rom;
        logic              ram;
        logic [NUM_IO-1:0] io;
        logic [7:0]        data;
        logic [15:0]       wait_pat;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: channel k owns ports 0x84+2k and 0x85+2k; upper address byte is irrelevant for I/O.
    function automatic exp_t model(input string tag, input bit is_io, input bit is_rd,
                                   input logic [15:0] addr, input int hold);
        exp_t e;
        int   a;
        int   n;
        int   w;
        e.tag  = tag;
        e.rom  = !is_io && (addr < 16'h8000);
        e.ram  = !is_io && (addr >= 16'h8000);
        e.io   = '0;
        e.data = 8'hFF;
        a = int'(addr[7:0]);
        if (is_io && a >= 'h84 && a < 'h84 + 2*NUM_IO) begin
            e.io[(a - 'h84) / 2] = 1'b1;
            if (is_rd) e.data = io_bytes[(a - 'h84) / 2];
        end
        if (is_rd && e.rom) e.data = 8'h3E;
        if (is_rd && e.ram) e.data = 8'hA5;
        n = is_io ? IO_WAIT : MEM_WAIT;
        w = (n < hold) ? n : hold;
        e.wait_pat = 16'((32'd1 << w) - 1);
        return e;
    endfunction

    task automatic do_access(input string tag, input bit is_io, input bit is_rd,
                             input logic [15:0] addr, input int hold);
        exp_t        e;
        logic        g_rom;
        logic        g_ram;
        logic [NUM_IO-1:0] g_io;
        logic [7:0]  g_data;
        logic [15:0] pat;
        sb_q.push_back(model(tag, is_io, is_rd, addr, hold));
        @(posedge cpu_clk); #1;
        cpu_addr = addr;
        cpu_mreq = !is_io;
        cpu_iorq = is_io;
        cpu_rd   = is_rd;
        cpu_wr   = !is_rd;
        pat = '0;
        g_rom = 1'b0; g_ram = 1'b0; g_io = '0; g_data = '0;
        for (int c = 0; c < hold; c++) begin
            @(negedge cpu_clk);
            if (c == 0) begin
                g_rom  = rom_ce;
                g_ram  = ram_ce;
                g_io   = io_ce;
                g_data = cpu_data_in;
            end
            pat[c] = cpu_wait;
        end
        @(posedge cpu_clk); #1;
        cpu_mreq = 1'b0;
        cpu_iorq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        #1;
        e = sb_q.pop_front();
        check({e.tag, "/rom_ce"},   g_rom,  e.rom);
        check({e.tag, "/ram_ce"},   g_ram,  e.ram);
        check({e.tag, "/io_ce"},    g_io,   e.io);
        check({e.tag, "/data"},     g_data, e.data);
        check({e.tag, "/wait_pat"}, pat,    e.wait_pat);
        check({e.tag, "/wait_after_drop"}, cpu_wait, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset phase: a memory read is held on the bus; nothing may be selected.
        cpu_mreq = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0000;
        #12;
        check("rst/cpu_rst",  cpu_rst,     1'b1);
        check("rst/rom_ce",   rom_ce,      1'b0);
        check("rst/ram_ce",   ram_ce,      1'b0);
        check("rst/io_ce",    io_ce,       '0);
        check("rst/wait",     cpu_wait,    1'b0);
        check("rst/data",     cpu_data_in, 8'hFF);
        check("rst/bus_err",  bus_err,     1'b0);
        check("rst/err_port", err_port,    8'h00);

        @(negedge cpu_clk);
        n_RST = 1'b1;
        for (int k = 1; k <= RST_CYCLES; k++) begin
            @(posedge cpu_clk); #1;
            check($sformatf("rel/cpu_rst_e%0d", k), cpu_rst, (k < RST_CYCLES));
            check($sformatf("rel/rom_ce_e%0d", k),  rom_ce,  (k >= RST_CYCLES));
        end
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;

        // Memory decode and read mux, zero memory wait states
        do_access("rom_top",  1'b0, 1'b1, 16'h7FFF, 3);
        do_access("ram_base", 1'b0, 1'b1, 16'h8000, 3);
        do_access("rom_zero", 1'b0, 1'b1, 16'h0000, 2);
        do_access("ram_wr",   1'b0, 1'b0, 16'hFFFF, 2);

        // I/O decode with two wait states
        do_access("io_wr_ch1",   1'b1, 1'b0, 16'h0086, 5);
        do_access("io_ch1_hi",   1'b1, 1'b1, 16'hAB87, 4);
        do_access("io_rd_abort", 1'b1, 1'b1, 16'h0085, 1);
        do_access("io_rd_ch0",   1'b1, 1'b1, 16'h0085, 3);
        do_access("io_ch3",      1'b1, 1'b1, 16'h008B, 3);

        // Unmapped I/O: only the first one is captured
        do_access("unmap_10", 1'b1, 1'b1, 16'h0010, 3);
        check("err1/bus_err",  bus_err,  ERR_EN);
        check("err1/err_port", err_port, ERR_EN ? 8'h10 : 8'h00);
        do_access("unmap_20", 1'b1, 1'b1, 16'h0020, 3);
        do_access("unmap_8c", 1'b1, 1'b0, 16'h008C, 3);
        do_access("unmap_83", 1'b1, 1'b1, 16'h0083, 3);
        check("err2/bus_err",  bus_err,  ERR_EN);
        check("err2/err_port", err_port, ERR_EN ? 8'h10 : 8'h00);

        // Mid-run reset assertion takes effect without a clock edge
        @(posedge cpu_clk); #2;
        cpu_iorq = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0085;
        n_RST    = 1'b0;
        #1;
        check("rerst/cpu_rst",  cpu_rst,  1'b1);
        check("rerst/io_ce",    io_ce,    '0);
        check("rerst/wait",     cpu_wait, 1'b0);
        check("rerst/bus_err",  bus_err,  1'b0);
        check("rerst/err_port", err_port, 8'h00);
        cpu_iorq = 1'b0;
        cpu_rd   = 1'b0;
        @(negedge cpu_clk);
        n_RST = 1'b1;
        for (int k = 1; k <= RST_CYCLES; k++) begin
            @(posedge cpu_clk); #1;
            if (k == RST_CYCLES - 1) check("rerel/cpu_rst_before", cpu_rst, 1'b1);
        end
        check("rerel/cpu_rst_after", cpu_rst, 1'b0);
        do_access("post_rst_io", 1'b1, 1'b1, 16'h0089, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
